// File: rtl/serial_alu_pkg.sv
// Shared types, slice opcodes and the initial-carry rule for the bit-serial ALU sequencer.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Arithmetic opcodes (mode = 0)
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_ANB  = 3'b011;
  localparam logic [2:0] OP_PASS = 3'b100;
  localparam logic [2:0] OP_DEC  = 3'b101;
  localparam logic [2:0] OP_ADC  = 3'b110;

  // Logic opcodes (mode = 1); 1xx yields zero
  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOTA = 3'b011;

  // Carry fed into bit 0; subtract and increment need the +1 injected here.
  function automatic logic cin0_f(input logic [2:0] op, input logic mode, input logic carry_in);
    logic c;
    c = 1'b0;
    if (!mode) begin
      case (op)
        OP_SUB, OP_INC: c = 1'b1;
        OP_ADC:         c = carry_in;
        default:        c = 1'b0;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/serial_alu_flags.sv
// Condition flags from the completed result, the slice's final carry and the carry into the MSB.
module serial_alu_flags
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH-1:0] result,
  input  logic             final_carry,
  input  logic             msb_cin,
  input  logic             mode,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             sign_flag,
  output logic             overflow_flag
);

  // Logic ops never produce carry or signed overflow.
  assign carry_flag    = mode ? 1'b0 : final_carry;
  assign overflow_flag = mode ? 1'b0 : (msb_cin ^ final_carry);
  assign zero_flag     = ~|result;
  assign sign_flag     = result[WIDTH-1];

endmodule

// File: rtl/serial_alu_sequencer.sv
// Drives an external one-bit ALU slice LSB first, chaining its carry and collecting result and flags.
module serial_alu_sequencer
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [2:0]       operation,
  input  logic             mode,
  input  logic             carry_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             sign_flag,
  output logic             overflow_flag,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [2:0]       alu_op,
  output logic             alu_mode,
  input  logic             alu_out,
  input  logic             alu_carry
);

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic [2:0]       op_r;
  logic             mode_r;
  logic             cin0_r;
  logic             carry_reg;

  logic             running;
  logic             last_bit;
  logic             cin_now;
  logic [WIDTH-1:0] result_final;
  logic             carry_next;
  logic             zero_next;
  logic             sign_next;
  logic             overflow_next;

  assign running  = (state == RUN);
  assign last_bit = (idx == IDXW'(WIDTH - 1));
  assign cin_now  = (idx == '0) ? cin0_r : carry_reg;
  assign ready    = (state == IDLE);

  // Slice inputs come straight from registers and are forced low outside RUN.
  assign alu_a    = running & opa_r[idx];
  assign alu_b    = running & opb_r[idx];
  assign alu_cin  = running & cin_now;
  assign alu_op   = running ? op_r : 3'b000;
  assign alu_mode = running & mode_r;

  // On the last bit the MSB is still on the slice output, so the flags see it merged in.
  assign result_final = {alu_out, result[WIDTH-2:0]};

  serial_alu_flags #(
    .WIDTH(WIDTH)
  ) u_flags (
    .result        (result_final),
    .final_carry   (alu_carry),
    .msb_cin       (alu_cin),
    .mode          (mode_r),
    .carry_flag    (carry_next),
    .zero_flag     (zero_next),
    .sign_flag     (sign_next),
    .overflow_flag (overflow_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      opa_r         <= '0;
      opb_r         <= '0;
      op_r          <= 3'b000;
      mode_r        <= 1'b0;
      cin0_r        <= 1'b0;
      carry_reg     <= 1'b0;
      done          <= 1'b0;
      result        <= '0;
      carry_flag    <= 1'b0;
      zero_flag     <= 1'b0;
      sign_flag     <= 1'b0;
      overflow_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opa_r     <= opa;
            opb_r     <= opb;
            op_r      <= operation;
            mode_r    <= mode;
            cin0_r    <= cin0_f(operation, mode, carry_in);
            carry_reg <= 1'b0;
            idx       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          result[idx] <= alu_out;
          carry_reg   <= alu_carry;
          if (last_bit) begin
            idx           <= '0;
            done          <= 1'b1;
            carry_flag    <= carry_next;
            zero_flag     <= zero_next;
            sign_flag     <= sign_next;
            overflow_flag <= overflow_next;
            state         <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Scoreboard bench: directed vectors push expected results, a monitor pops them on each done pulse.
module tb_serial_alu_sequencer;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;

  // 8-bit instance
  logic         start8, mode8, cin8;
  logic [7:0]   opa8, opb8;
  logic [2:0]   op8;
  logic         ready8, done8, cf8, zf8, sf8, vf8;
  logic [7:0]   result8;
  logic         aa8, ab8, acin8, amode8, aout8, acarry8;
  logic [2:0]   aop8;

  // 128-bit instance
  logic         start128, mode128, cin128;
  logic [127:0] opa128, opb128;
  logic [2:0]   op128;
  logic         ready128, done128, cf128, zf128, sf128, vf128;
  logic [127:0] result128;
  logic         aa128, ab128, acin128, amode128, aout128, acarry128;
  logic [2:0]   aop128;

  logic         cin_hi8;

  typedef struct {
    string        name;
    logic [127:0] result;
    logic [3:0]   flags;
    int           due;
  } exp_t;

  exp_t q8[$];
  exp_t q128[$];

  serial_alu_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .opa(opa8), .opb(opb8),
    .operation(op8), .mode(mode8), .carry_in(cin8),
    .ready(ready8), .done(done8), .result(result8),
    .carry_flag(cf8), .zero_flag(zf8), .sign_flag(sf8), .overflow_flag(vf8),
    .alu_a(aa8), .alu_b(ab8), .alu_cin(acin8), .alu_op(aop8), .alu_mode(amode8),
    .alu_out(aout8), .alu_carry(acarry8)
  );

  serial_alu_sequencer #(.WIDTH(128)) dut128 (
    .clk(clk), .rst(rst), .start(start128), .opa(opa128), .opb(opb128),
    .operation(op128), .mode(mode128), .carry_in(cin128),
    .ready(ready128), .done(done128), .result(result128),
    .carry_flag(cf128), .zero_flag(zf128), .sign_flag(sf128), .overflow_flag(vf128),
    .alu_a(aa128), .alu_b(ab128), .alu_cin(acin128), .alu_op(aop128), .alu_mode(amode128),
    .alu_out(aout128), .alu_carry(acarry128)
  );

  // Behavioural model of the external one-bit slice: returns {carry, out}.
  function automatic logic [1:0] slice_f(input logic a, input logic b, input logic cin,
                                         input logic [2:0] op, input logic m);
    logic [1:0] r;
    logic       bb;
    r  = 2'b00;
    bb = 1'b0;
    if (m) begin
      case (op)
        3'b000:  r = {1'b0, a & b};
        3'b001:  r = {1'b0, a | b};
        3'b010:  r = {1'b0, a ^ b};
        3'b011:  r = {1'b0, ~a};
        default: r = 2'b00;
      endcase
    end else begin
      case (op)
        3'b000, 3'b110: bb = b;
        3'b001, 3'b011: bb = ~b;
        3'b101:         bb = 1'b1;
        default:        bb = 1'b0;
      endcase
      r = {1'b0, a} + {1'b0, bb} + {1'b0, cin};
    end
    return r;
  endfunction

  always_comb {acarry8, aout8}     = slice_f(aa8, ab8, acin8, aop8, amode8);
  always_comb {acarry128, aout128} = slice_f(aa128, ab128, acin128, aop128, amode128);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && !ready8 && acin8) cin_hi8 = 1'b1;
      if (!rst && done8) begin
        if (q8.size() == 0) begin
          check("d8_unexpected_done", {127'd0, done8}, 128'd0);
        end else begin
          e = q8.pop_front();
          $display("[TB] w8 %s result=%h flags(czsv)=%b cycle=%0d", e.name, result8,
                   {cf8, zf8, sf8, vf8}, cyc);
          check({e.name, "_result"}, 128'(result8), e.result);
          check({e.name, "_flags"}, 128'({cf8, zf8, sf8, vf8}), 128'(e.flags));
          check({e.name, "_latency"}, 128'(cyc), 128'(e.due));
        end
      end
      if (!rst && done128) begin
        if (q128.size() == 0) begin
          check("d128_unexpected_done", {127'd0, done128}, 128'd0);
        end else begin
          e = q128.pop_front();
          $display("[TB] w128 %s result=%h flags(czsv)=%b cycle=%0d", e.name, result128,
                   {cf128, zf128, sf128, vf128}, cyc);
          check({e.name, "_result"}, result128, e.result);
          check({e.name, "_flags"}, 128'({cf128, zf128, sf128, vf128}), 128'(e.flags));
          check({e.name, "_latency"}, 128'(cyc), 128'(e.due));
        end
      end
    end
  endtask

  task automatic wait_ready(input bit big);
    int t;
    t = 0;
    while (!(big ? ready128 : ready8) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!(big ? ready128 : ready8))
      check(big ? "ready128_timeout" : "ready8_timeout", {127'd0, big ? ready128 : ready8}, 128'd1);
  endtask

  // Called at a negedge; the following posedge is the accept edge.
  task automatic issue(input bit big, input logic [127:0] a, input logic [127:0] b,
                       input logic [2:0] op, input logic m, input logic ci,
                       input logic [127:0] er, input logic [3:0] ef,
                       input bit expect_done, input string name);
    exp_t e;
    wait_ready(big);
    if (big) begin
      opa128 = a; opb128 = b; op128 = op; mode128 = m; cin128 = ci; start128 = 1'b1;
    end else begin
      opa8 = a[7:0]; opb8 = b[7:0]; op8 = op; mode8 = m; cin8 = ci; start8 = 1'b1;
    end
    e.name   = name;
    e.result = er;
    e.flags  = ef;
    e.due    = cyc + (big ? 129 : 9);
    if (expect_done) begin
      if (big) q128.push_back(e);
      else     q8.push_back(e);
    end
    cin_hi8 = 1'b0;
    @(negedge clk);
    start8   = 1'b0;
    start128 = 1'b0;
  endtask

  initial begin
    int cnt;
    tests = 0; fails = 0; cin_hi8 = 1'b0;
    rst = 1'b1;
    start8 = 0; opa8 = '0; opb8 = '0; op8 = '0; mode8 = 0; cin8 = 0;
    start128 = 0; opa128 = '0; opb128 = '0; op128 = '0; mode128 = 0; cin128 = 0;
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    check("rst_ready8", {127'd0, ready8}, 128'd1);
    check("rst_done8", {127'd0, done8}, 128'd0);
    check("rst_result8", 128'(result8), 128'd0);
    check("rst_flags8", 128'({cf8, zf8, sf8, vf8}), 128'd0);
    check("rst_alu8", 128'({aa8, ab8, acin8, aop8, amode8}), 128'd0);
    check("rst_ready128", {127'd0, ready128}, 128'd1);
    check("rst_result128", result128, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // flags column is {carry, zero, sign, overflow}
    issue(0, 8'h7F, 8'h01, 3'b000, 0, 0, 8'h80, 4'b0011, 1, "add_7f_01");
    issue(0, 8'h05, 8'h05, 3'b001, 0, 0, 8'h00, 4'b1100, 1, "sub_05_05");
    issue(0, 8'hF0, 8'hFF, 3'b010, 1, 1, 8'h0F, 4'b0000, 1, "xor_f0_ff");
    wait_ready(0);
    check("xor_alu_cin_low", {127'd0, cin_hi8}, 128'd0);
    issue(0, 8'h10, 8'h20, 3'b110, 0, 1, 8'h31, 4'b0000, 1, "adc_10_20_c1");
    issue(0, 8'h00, 8'h55, 3'b101, 0, 0, 8'hFF, 4'b0010, 1, "dec_00");
    issue(0, 8'h03, 8'h05, 3'b001, 0, 0, 8'hFE, 4'b0010, 1, "sub_03_05");
    issue(0, 8'h05, 8'h05, 3'b011, 0, 1, 8'hFF, 4'b0010, 1, "anb_05_05");
    issue(0, 8'h80, 8'hFF, 3'b100, 0, 0, 8'h80, 4'b0010, 1, "pass_80");
    issue(0, 8'h7F, 8'h00, 3'b010, 0, 0, 8'h80, 4'b0011, 1, "inc_7f");
    issue(0, 8'hFF, 8'h01, 3'b000, 0, 0, 8'h00, 4'b1100, 1, "add_ff_01");
    issue(0, 8'hF0, 8'h3C, 3'b000, 1, 0, 8'h30, 4'b0000, 1, "and_f0_3c");
    issue(0, 8'hF0, 8'h3C, 3'b001, 1, 0, 8'hFC, 4'b0010, 1, "or_f0_3c");
    issue(0, 8'hA5, 8'h5A, 3'b110, 1, 1, 8'h00, 4'b0100, 1, "logic_110");
    issue(0, 8'h3C, 8'hFF, 3'b111, 0, 1, 8'h3C, 4'b0000, 1, "pass_111_3c");
    issue(0, 8'h7F, 8'h7F, 3'b110, 0, 0, 8'hFE, 4'b0011, 1, "adc_7f_7f_c0");
    issue(0, 8'h0F, 8'h00, 3'b011, 1, 0, 8'hF0, 4'b0010, 1, "nota_0f");

    // Abort mid-RUN at idx 3 (A bit 3 is the only set bit visible there).
    issue(0, 8'h18, 8'h22, 3'b000, 0, 0, 8'h00, 4'b0000, 0, "aborted");
    repeat (3) @(negedge clk);
    check("abort_alu_a_idx3", {127'd0, aa8}, 128'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_ready8", {127'd0, ready8}, 128'd1);
    check("abort_result8", 128'(result8), 128'd0);
    check("abort_flags8", 128'({cf8, zf8, sf8, vf8, done8}), 128'd0);
    check("abort_alu8", 128'({aa8, ab8, acin8, aop8, amode8}), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue(0, 8'h18, 8'h22, 3'b000, 0, 0, 8'h3A, 4'b0000, 1, "add_after_abort");

    // 128-bit increment of all-ones, with an ignored start pulse mid-RUN.
    issue(1, {128{1'b1}}, 128'd0, 3'b010, 0, 0, 128'd0, 4'b1100, 1, "inc128_ones");
    cnt = 0;
    while (!ready128 && cnt < 400) begin
      cnt++;
      if (cnt == 10) begin
        opa128 = 128'd5; opb128 = 128'd7; op128 = 3'b000; start128 = 1'b1;
      end else begin
        start128 = 1'b0;
      end
      @(negedge clk);
    end
    start128 = 1'b0;
    check("inc128_busy_cycles", 128'(cnt), 128'd129);
    issue(1, 128'd0, 128'd1, 3'b001, 0, 0, {128{1'b1}}, 4'b0010, 1, "sub128_0_1");

    wait_ready(0);
    wait_ready(1);
    repeat (3) @(negedge clk);
    check("q8_drained", 128'(q8.size()), 128'd0);
    check("q128_drained", 128'(q128.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
